// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle RV32-subset controller: FSM states,
// opcodes, ALUop classes, ALU op codes and PC source selects.
package multicycle_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_FETCH  = 3'd0,
    ST_DECODE = 3'd1,
    ST_EXEC   = 3'd2,
    ST_MEM    = 3'd3,
    ST_WB     = 3'd4,
    ST_TRAP   = 3'd5
  } state_e;

  localparam logic [6:0] OPC_R   = 7'b0110011;
  localparam logic [6:0] OPC_I   = 7'b0010011;
  localparam logic [6:0] OPC_LW  = 7'b0000011;
  localparam logic [6:0] OPC_SW  = 7'b0100011;
  localparam logic [6:0] OPC_BEQ = 7'b1100011;
  localparam logic [6:0] OPC_JAL = 7'b1101111;

  localparam logic [1:0] ALUOP_ADD = 2'b00;
  localparam logic [1:0] ALUOP_BR  = 2'b01;
  localparam logic [1:0] ALUOP_R   = 2'b10;

  localparam logic [2:0] OP_AND = 3'b000;
  localparam logic [2:0] OP_OR  = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b110;
  localparam logic [2:0] OP_SLT = 3'b111;

  localparam logic [1:0] PCSEL_PC4   = 2'b00;
  localparam logic [1:0] PCSEL_BR    = 2'b01;
  localparam logic [1:0] PCSEL_JMP   = 2'b10;
  localparam logic [1:0] PCSEL_ENTRY = 2'b11;

  function automatic logic opcode_legal(input logic [6:0] opc);
    case (opc)
      OPC_R, OPC_I, OPC_LW, OPC_SW, OPC_BEQ, OPC_JAL: return 1'b1;
      default:                                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/multicycle_ctrl_alu_ctrl_dec.sv
// ALU control decode: ALUop class plus funct3/funct7[5] to ALU op code,
// flagging funct3 values the datapath cannot execute.
module alu_ctrl_dec
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W   = 3,
  parameter bit EN_SUB = 1'b1
) (
  input  logic [1:0]      i_aluop,
  input  logic            i_is_imm,
  input  logic [2:0]      i_funct3,
  input  logic            i_funct7b5,
  output logic [OP_W-1:0] o_op,
  output logic            o_illegal
);

  // Returns {illegal, op}; 000 is ADD here, the caller picks SUB when allowed.
  function automatic logic [3:0] f3_decode(input logic [2:0] f3);
    case (f3)
      3'b000:  return {1'b0, OP_ADD};
      3'b010:  return {1'b0, OP_SLT};
      3'b110:  return {1'b0, OP_OR};
      3'b111:  return {1'b0, OP_AND};
      default: return {1'b1, OP_ADD};
    endcase
  endfunction

  logic [2:0] w_op;
  logic [3:0] w_f3;

  assign w_f3 = f3_decode(i_funct3);

  // Op code selection per ALUop class
  always_comb begin
    w_op      = OP_ADD;
    o_illegal = 1'b0;
    case (i_aluop)
      ALUOP_ADD: begin
        if (i_is_imm) begin
          w_op      = w_f3[2:0];
          o_illegal = w_f3[3];
        end else begin
          w_op      = OP_ADD;
        end
      end
      ALUOP_BR: w_op = OP_SUB;
      ALUOP_R: begin
        o_illegal = w_f3[3];
        if (EN_SUB && i_funct7b5 && (i_funct3 == 3'b000)) begin
          w_op = OP_SUB;
        end else begin
          w_op = w_f3[2:0];
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

  assign o_op = OP_W'(w_op);

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle main control for the RV32 subset: FETCH/DECODE/EXEC/MEM/WB
// sequencing with memory handshakes, wait-timeout trap and datapath strobes.
module multicycle_ctrl
  import multicycle_ctrl_pkg::*;
#(
  parameter int OP_W        = 3,
  parameter int MEM_TIMEOUT = 16,
  parameter bit EN_SUB      = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            INT,
  input  logic [31:0]     ins,
  output logic            imem_req,
  input  logic            imem_ack,
  input  logic            dmem_ack,
  input  logic            zero,
  output logic            ir_we,
  output logic            pc_we,
  output logic [1:0]      pc_sel,
  output logic            reg_we,
  output logic            alu_src,
  output logic            mem2reg,
  output logic            mem_read,
  output logic            mem_write,
  output logic [1:0]      ALUop,
  output logic [OP_W-1:0] op,
  output logic [2:0]      state_o,
  output logic            trap
);

  localparam int              WAIT_W    = $clog2(MEM_TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_ZERO = WAIT_W'(0);
  localparam logic [WAIT_W-1:0] WAIT_ONE  = WAIT_W'(1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_TIMEOUT);

  state_e            r_state, w_state_nxt;
  logic [WAIT_W-1:0] r_wait;
  logic [6:0]        r_opcode;
  logic [2:0]        r_funct3;
  logic              r_funct7b5;

  logic       w_wait_inc, w_dec_illegal, w_is_lw;
  logic       w_imem_req, w_ir_we, w_pc_we, w_reg_we, w_alu_src;
  logic       w_mem2reg, w_mem_read, w_mem_write;
  logic [1:0] w_pc_sel, w_aluop;
  logic       w_unused_ins;

  assign w_unused_ins = ^{ins[31], ins[29:15], ins[11:7]};
  assign w_is_lw      = (r_opcode == OPC_LW);

  // ALUop class from the latched opcode
  always_comb begin
    case (r_opcode)
      OPC_R:   w_aluop = ALUOP_R;
      OPC_BEQ: w_aluop = ALUOP_BR;
      default: w_aluop = ALUOP_ADD;
    endcase
  end

  alu_ctrl_dec #(.OP_W(OP_W), .EN_SUB(EN_SUB)) u_alu_ctrl_dec (
    .i_aluop    (w_aluop),
    .i_is_imm   (r_opcode == OPC_I),
    .i_funct3   (r_funct3),
    .i_funct7b5 (r_funct7b5),
    .o_op       (op),
    .o_illegal  (w_dec_illegal)
  );

  // Next-state and strobe decode
  always_comb begin
    w_state_nxt = r_state;
    w_wait_inc  = 1'b0;
    w_imem_req  = 1'b0;
    w_ir_we     = 1'b0;
    w_pc_we     = 1'b0;
    w_pc_sel    = PCSEL_PC4;
    w_reg_we    = 1'b0;
    w_alu_src   = 1'b0;
    w_mem2reg   = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    case (r_state)
      ST_FETCH: begin
        // An interrupt only redirects before any fetch cycle has been spent waiting.
        if (INT && (r_wait == WAIT_ZERO)) begin
          w_pc_we  = 1'b1;
          w_pc_sel = PCSEL_ENTRY;
        end else begin
          w_imem_req = 1'b1;
          if (imem_ack) begin
            w_ir_we     = 1'b1;
            w_state_nxt = ST_DECODE;
          end else if (r_wait == WAIT_LAST) begin
            w_state_nxt = ST_TRAP;
          end else begin
            w_wait_inc  = 1'b1;
          end
        end
      end
      ST_DECODE: begin
        if (!opcode_legal(r_opcode) || w_dec_illegal) begin
          w_state_nxt = ST_TRAP;
        end else begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (r_opcode)
          OPC_BEQ: begin
            w_pc_we     = 1'b1;
            w_pc_sel    = zero ? PCSEL_BR : PCSEL_PC4;
            w_state_nxt = ST_FETCH;
          end
          OPC_JAL: begin
            w_alu_src   = 1'b1;
            w_pc_we     = 1'b1;
            w_pc_sel    = PCSEL_JMP;
            w_state_nxt = ST_FETCH;
          end
          OPC_LW, OPC_SW: begin
            w_alu_src   = 1'b1;
            w_state_nxt = ST_MEM;
          end
          OPC_I: begin
            w_alu_src   = 1'b1;
            w_state_nxt = ST_WB;
          end
          OPC_R:   w_state_nxt = ST_WB;
          default: w_state_nxt = ST_TRAP;
        endcase
      end
      ST_MEM: begin
        if (w_is_lw) begin
          w_mem_read  = 1'b1;
        end else begin
          w_mem_write = 1'b1;
        end
        if (dmem_ack) begin
          if (w_is_lw) begin
            w_state_nxt = ST_WB;
          end else begin
            w_pc_we     = 1'b1;
            w_state_nxt = ST_FETCH;
          end
        end else if (r_wait == WAIT_LAST) begin
          w_state_nxt = ST_TRAP;
        end else begin
          w_wait_inc  = 1'b1;
        end
      end
      ST_WB: begin
        w_reg_we    = 1'b1;
        w_mem2reg   = w_is_lw;
        w_pc_we     = 1'b1;
        w_state_nxt = ST_FETCH;
      end
      ST_TRAP: w_state_nxt = ST_TRAP;
      default: w_state_nxt = ST_TRAP;
    endcase
  end

  // State, saturating wait counter and IR field latches
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= ST_FETCH;
      r_wait     <= WAIT_ZERO;
      r_opcode   <= 7'd0;
      r_funct3   <= 3'd0;
      r_funct7b5 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (w_wait_inc) begin
        r_wait <= (r_wait == WAIT_MAX) ? r_wait : (r_wait + WAIT_ONE);
      end else begin
        r_wait <= WAIT_ZERO;
      end
      if (w_ir_we) begin
        r_opcode   <= ins[6:0];
        r_funct3   <= ins[14:12];
        r_funct7b5 <= ins[30];
      end
    end
  end

  // Reset low suppresses every strobe, including any abandoned request.
  assign imem_req  = rst_n & w_imem_req;
  assign ir_we     = rst_n & w_ir_we;
  assign pc_we     = rst_n & w_pc_we;
  assign pc_sel    = rst_n ? w_pc_sel : PCSEL_PC4;
  assign reg_we    = rst_n & w_reg_we;
  assign alu_src   = rst_n & w_alu_src;
  assign mem2reg   = rst_n & w_mem2reg;
  assign mem_read  = rst_n & w_mem_read;
  assign mem_write = rst_n & w_mem_write;
  assign ALUop     = w_aluop;
  assign state_o   = r_state;
  assign trap      = (r_state == ST_TRAP);

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Randomized cycle-level check of multicycle_ctrl against an instruction-level
// model that expands each instruction into its expected per-cycle strobes.
module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0, INT = 1'b0, imem_ack = 1'b0, dmem_ack = 1'b0, zero = 1'b0;
  logic [31:0] ins = 32'd0;
  logic        imem_req, ir_we, pc_we, reg_we, alu_src, mem2reg, mem_read, mem_write, trap;
  logic [1:0]  pc_sel, ALUop;
  logic [2:0]  op, state_o;
  logic        imem_req_b, ir_we_b, pc_we_b, reg_we_b, alu_src_b, mem2reg_b, mem_read_b, mem_write_b, trap_b;
  logic [1:0]  pc_sel_b, ALUop_b;
  logic [2:0]  op_b, state_o_b;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  multicycle_ctrl #(.OP_W(3), .MEM_TIMEOUT(16), .EN_SUB(1'b1)) u_dut (
    .clk(clk), .rst_n(rst_n), .INT(INT), .ins(ins), .imem_req(imem_req), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .zero(zero), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .alu_src(alu_src), .mem2reg(mem2reg), .mem_read(mem_read),
    .mem_write(mem_write), .ALUop(ALUop), .op(op), .state_o(state_o), .trap(trap));

  multicycle_ctrl #(.OP_W(3), .MEM_TIMEOUT(16), .EN_SUB(1'b0)) u_dut_nosub (
    .clk(clk), .rst_n(rst_n), .INT(INT), .ins(ins), .imem_req(imem_req_b), .imem_ack(imem_ack),
    .dmem_ack(dmem_ack), .zero(zero), .ir_we(ir_we_b), .pc_we(pc_we_b), .pc_sel(pc_sel_b),
    .reg_we(reg_we_b), .alu_src(alu_src_b), .mem2reg(mem2reg_b), .mem_read(mem_read_b),
    .mem_write(mem_write_b), .ALUop(ALUop_b), .op(op_b), .state_o(state_o_b), .trap(trap_b));

  // Observed: {state, trap, req, ir_we, pc_we, pc_sel, reg_we, alu_src, mem2reg, mem_read, mem_write, ALUop, op, op(no SUB)}
  logic [21:0] obs;
  assign obs = {state_o, trap, imem_req, ir_we, pc_we, pc_sel, reg_we, alu_src, mem2reg,
                mem_read, mem_write, ALUop, op, op_b};

  typedef struct packed {
    logic        rst_n, intr, iack, dack, zero;
    logic [31:0] ins;
    logic [21:0] exp, mask;
  } cyc_t;

  cyc_t        plan[$];
  logic [31:0] m_latched = 32'd0;

  function automatic logic rb();
    return logic'($urandom_range(0, 1));
  endfunction

  function automatic logic [2:0] ref_op(input logic [31:0] w, input bit sub_en);
    logic [6:0] opc = w[6:0];
    if (opc == 7'h33 || opc == 7'h13) begin
      case (w[14:12])
        3'b000:  return (opc == 7'h33 && sub_en && w[30]) ? 3'b110 : 3'b010;
        3'b010:  return 3'b111;
        3'b110:  return 3'b001;
        3'b111:  return 3'b000;
        default: return 3'b010;
      endcase
    end
    if (opc == 7'h63) return 3'b110;
    return 3'b010;
  endfunction

  function automatic logic [1:0] ref_aluop(input logic [31:0] w);
    if (w[6:0] == 7'h33) return 2'b10;
    if (w[6:0] == 7'h63) return 2'b01;
    return 2'b00;
  endfunction

  function automatic bit ref_legal(input logic [31:0] w);
    logic [2:0] f3 = w[14:12];
    if (w[6:0] == 7'h33 || w[6:0] == 7'h13)
      return (f3 == 3'b000) || (f3 == 3'b010) || (f3 == 3'b110) || (f3 == 3'b111);
    return (w[6:0] == 7'h03) || (w[6:0] == 7'h23) || (w[6:0] == 7'h63) || (w[6:0] == 7'h6F);
  endfunction

  // strobes = {trap, req, ir_we, pc_we, pc_sel[1:0], reg_we, alu_src, mem2reg, mem_read, mem_write}
  task automatic add_cyc(input logic r, input logic intr, input logic iack, input logic dack,
                         input logic zv, input logic [31:0] w, input logic [2:0] st,
                         input logic [10:0] strobes);
    cyc_t c;
    c.rst_n = r; c.intr = intr; c.iack = iack; c.dack = dack; c.zero = zv; c.ins = w;
    c.exp  = {st, strobes, ref_aluop(m_latched), ref_op(m_latched, 1'b1), ref_op(m_latched, 1'b0)};
    c.mask = r ? 22'h3FFFFF : 22'h03FF00;
    plan.push_back(c);
  endtask

  task automatic plan_reset();
    add_cyc(1'b0, rb(), rb(), rb(), rb(), $urandom, 3'd0, 11'd0);
    m_latched = 32'd0;
  endtask

  // Expand one instruction into its expected cycles from the architectural rules.
  task automatic plan_instr(input logic [31:0] w, input int idly, input int ddly,
                            input logic zv, input bit do_int);
    bit is_lw  = (w[6:0] == 7'h03);
    bit is_sw  = (w[6:0] == 7'h23);
    bit is_beq = (w[6:0] == 7'h63);
    bit is_jal = (w[6:0] == 7'h6F);
    bit is_r   = (w[6:0] == 7'h33);
    bit is_i   = (w[6:0] == 7'h13);
    logic       ack;
    logic [1:0] sel;
    if (do_int)
      add_cyc(1'b1, 1'b1, 1'b0, 1'b0, rb(), $urandom, 3'd0, {1'b0, 1'b0, 1'b0, 1'b1, 2'b11, 5'b0});
    for (int c = 0; c <= idly; c++) begin
      ack = (c == idly);
      add_cyc(1'b1, (c > 0) ? rb() : 1'b0, ack, 1'b0, rb(), ack ? w : $urandom, 3'd0,
              {1'b0, 1'b1, ack, 8'b0});
    end
    m_latched = w;
    add_cyc(1'b1, rb(), 1'b0, 1'b0, rb(), $urandom, 3'd1, 11'd0);
    if (!ref_legal(w)) begin
      add_cyc(1'b1, 1'b1, 1'b0, 1'b0, rb(), $urandom, 3'd5, {1'b1, 10'b0});
      add_cyc(1'b1, 1'b1, 1'b0, 1'b0, rb(), $urandom, 3'd5, {1'b1, 10'b0});
      return;
    end
    sel = is_jal ? 2'b10 : ((is_beq && zv) ? 2'b01 : 2'b00);
    add_cyc(1'b1, rb(), 1'b0, 1'b0, zv, $urandom, 3'd2,
            {1'b0, 1'b0, 1'b0, is_beq | is_jal, sel, 1'b0, is_i | is_lw | is_sw | is_jal, 3'b0});
    if (is_lw || is_sw) begin
      for (int c = 0; c <= ddly; c++) begin
        ack = (c == ddly);
        add_cyc(1'b1, rb(), 1'b0, ack, rb(), $urandom, 3'd3,
                {1'b0, 1'b0, 1'b0, is_sw & ack, 2'b00, 3'b0, is_lw, is_sw});
      end
    end
    if (is_r || is_i || is_lw)
      add_cyc(1'b1, rb(), 1'b0, 1'b0, rb(), $urandom, 3'd4,
              {1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 1'b1, 1'b0, is_lw, 2'b0});
  endtask

  task automatic drive(input cyc_t c);
    @(negedge clk);
    rst_n = c.rst_n; INT = c.intr; imem_ack = c.iack; dmem_ack = c.dack;
    zero = c.zero; ins = c.ins;
    #1;
  endtask

  task automatic test_reset();
    plan_reset();
    plan_reset();
    add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 3'd0, {1'b0, 1'b1, 9'b0});
    plan_reset();
    foreach (plan[k]) begin
      drive(plan[k]);
      vectors++;
      if ((obs & plan[k].mask) !== (plan[k].exp & plan[k].mask)) begin
        miscompares++;
        $display("FAIL reset cyc %0d: got %h expected %h", k, obs & plan[k].mask, plan[k].exp & plan[k].mask);
      end
    end
    plan.delete();
  endtask

  task automatic test_alu_ops();
    plan_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    plan_instr(32'h402081B3, 1, 0, 1'b1, 1'b0);
    plan_instr(32'h0020E1B3, 0, 0, 1'b0, 1'b0);
    plan_instr(32'h0020F1B3, 2, 0, 1'b0, 1'b0);
    plan_instr(32'h0020A1B3, 0, 0, 1'b1, 1'b0);
    plan_instr(32'h40508093, 0, 0, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      vectors++;
      if ((obs & plan[k].mask) !== (plan[k].exp & plan[k].mask)) begin
        miscompares++;
        $display("FAIL alu_ops cyc %0d: got %h expected %h", k, obs & plan[k].mask, plan[k].exp & plan[k].mask);
      end
    end
    plan.delete();
  endtask

  task automatic test_mem_branch();
    plan_instr(32'h0000A103, 0, 3, 1'b0, 1'b0);
    plan_instr(32'h0020A223, 1, 2, 1'b1, 1'b0);
    plan_instr(32'h00208463, 0, 0, 1'b1, 1'b0);
    plan_instr(32'h00208463, 0, 0, 1'b0, 1'b0);
    plan_instr(32'h008000EF, 0, 0, 1'b1, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      vectors++;
      if ((obs & plan[k].mask) !== (plan[k].exp & plan[k].mask)) begin
        miscompares++;
        $display("FAIL mem_branch cyc %0d: got %h expected %h", k, obs & plan[k].mask, plan[k].exp & plan[k].mask);
      end
    end
    plan.delete();
  endtask

  task automatic test_interrupt();
    plan_instr(32'h002081B3, 0, 0, 1'b0, 1'b1);
    plan_instr(32'h0000A103, 3, 1, 1'b0, 1'b1);
    foreach (plan[k]) begin
      drive(plan[k]);
      vectors++;
      if ((obs & plan[k].mask) !== (plan[k].exp & plan[k].mask)) begin
        miscompares++;
        $display("FAIL interrupt cyc %0d: got %h expected %h", k, obs & plan[k].mask, plan[k].exp & plan[k].mask);
      end
    end
    plan.delete();
  endtask

  task automatic test_traps();
    // Fetch that is never acknowledged: 16 request cycles, then trap.
    for (int c = 0; c < 16; c++)
      add_cyc(1'b1, (c > 0) ? rb() : 1'b0, 1'b0, 1'b0, rb(), $urandom, 3'd0, {1'b0, 1'b1, 9'b0});
    for (int c = 0; c < 3; c++)
      add_cyc(1'b1, 1'b1, rb(), rb(), rb(), $urandom, 3'd5, {1'b1, 10'b0});
    plan_reset();
    plan_instr(32'h0000007F, 0, 0, 1'b0, 1'b0);
    plan_reset();
    plan_instr(32'h002091B3, 1, 0, 1'b0, 1'b0);
    plan_reset();
    plan_instr(32'h0050C093, 0, 0, 1'b0, 1'b0);
    plan_reset();
    // Data access never acknowledged also times out.
    plan_instr(32'h0020A223, 0, 0, 1'b0, 1'b0);
    plan.pop_back();
    for (int c = 0; c < 16; c++)
      add_cyc(1'b1, rb(), 1'b0, 1'b0, rb(), $urandom, 3'd3, {1'b0, 9'b0, 1'b1});
    add_cyc(1'b1, 1'b1, 1'b0, 1'b1, rb(), $urandom, 3'd5, {1'b1, 10'b0});
    plan_reset();
    add_cyc(1'b1, 1'b0, 1'b0, 1'b0, rb(), $urandom, 3'd0, {1'b0, 1'b1, 9'b0});
    plan_reset();
    foreach (plan[k]) begin
      drive(plan[k]);
      vectors++;
      if ((obs & plan[k].mask) !== (plan[k].exp & plan[k].mask)) begin
        miscompares++;
        $display("FAIL traps cyc %0d: got %h expected %h", k, obs & plan[k].mask, plan[k].exp & plan[k].mask);
      end
    end
    plan.delete();
  endtask

  task automatic test_reset_mid();
    // LW abandoned in MEM: reset cycle must show no strobe, then a clean fetch.
    plan_instr(32'h0000A103, 0, 0, 1'b0, 1'b0);
    plan.pop_back();
    plan.pop_back();
    add_cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, $urandom, 3'd3, {1'b0, 8'b0, 1'b1, 1'b0});
    plan_reset();
    plan_instr(32'h002081B3, 0, 0, 1'b0, 1'b0);
    foreach (plan[k]) begin
      drive(plan[k]);
      vectors++;
      if ((obs & plan[k].mask) !== (plan[k].exp & plan[k].mask)) begin
        miscompares++;
        $display("FAIL reset_mid cyc %0d: got %h expected %h", k, obs & plan[k].mask, plan[k].exp & plan[k].mask);
      end
    end
    plan.delete();
  endtask

  task automatic test_back_to_back();
    logic [6:0]  opcs [6] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F};
    logic [2:0]  f3s  [4] = '{3'b000, 3'b010, 3'b110, 3'b111};
    logic [31:0] w;
    for (int n = 0; n < 60; n++) begin
      w = $urandom;
      w[6:0] = opcs[$urandom_range(0, 5)];
      if (w[6:0] == 7'h33 || w[6:0] == 7'h13) w[14:12] = f3s[$urandom_range(0, 3)];
      plan_instr(w, $urandom_range(0, 4), $urandom_range(0, 4), rb(), ($urandom_range(0, 3) == 0));
    end
    foreach (plan[k]) begin
      drive(plan[k]);
      vectors++;
      if ((obs & plan[k].mask) !== (plan[k].exp & plan[k].mask)) begin
        miscompares++;
        $display("FAIL back_to_back cyc %0d: got %h expected %h", k, obs & plan[k].mask, plan[k].exp & plan[k].mask);
      end
    end
    plan.delete();
  endtask

  initial begin
    test_reset();
    test_alu_ops();
    test_mem_branch();
    test_interrupt();
    test_traps();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
